debounce_tick: RTL and testbench
================================

DEBOUNCE_TICK -- requirements
Module: debounce_tick

Interface
REQ-001 Parameter DB_CYCLES, default 4, number of consecutive stable synchronized samples required to accept a level change (legal range 2..65535).
REQ-002 Parameter REPEAT_CYCLES, default 16, auto-repeat period in clocks (legal range 2..65535; used only when the Configuration macro is defined).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset; sampled on the rising edge of clk.
REQ-005 btn  input  1  raw, asynchronous, bouncing push-button level.
REQ-006 tick  output  1  registered single-cycle pulse per accepted press; drives a downstream counter enable.
REQ-007 level  output  1  registered debounced button level.

Function
REQ-008 btn SHALL pass through a two-flop synchronizer (sync1, sync2); the FSM SHALL use only sync2.
REQ-009 FSM states SHALL be LOW, WAIT_HIGH, HIGH and WAIT_LOW, with a 16-bit stability counter cnt.
REQ-010 LOW: sync2=1 -> WAIT_HIGH with cnt=0; else remain.
REQ-011 WAIT_HIGH: sync2=0 -> LOW; sync2=1 and cnt=DB_CYCLES-1 -> HIGH; else cnt+1.
REQ-012 HIGH: sync2=0 -> WAIT_LOW with cnt=0; else remain.
REQ-013 WAIT_LOW: sync2=1 -> HIGH without a tick; sync2=0 and cnt=DB_CYCLES-1 -> LOW; else cnt+1.
REQ-014 tick SHALL be 1 for exactly one cycle, registered on the same edge as the WAIT_HIGH->HIGH transition; no other transition produces tick except per REQ-020.
REQ-015 level SHALL be 1 in HIGH and WAIT_LOW, 0 in LOW and WAIT_HIGH, registered with the state.
REQ-016 Latency: with btn=1 first sampled at edge 1 and held, tick SHALL be high during the cycle after edge DB_CYCLES+3 (edge 7 for DB_CYCLES=4).
REQ-017 Any sync2 glitch shorter than DB_CYCLES cycles SHALL produce no change on tick or level.
REQ-018 Two consecutive ticks SHALL be separated by at least 2*DB_CYCLES cycles without auto-repeat.
REQ-019 cnt SHALL never exceed DB_CYCLES-1 and SHALL never wrap.

Reset
REQ-020 reset=1 SHALL force sync1, sync2, cnt, tick and level to 0 and state to LOW on the next edge, overriding all other activity, including mid-debounce and mid-pulse (a pending tick is discarded).
REQ-021 If btn is high when reset deasserts, a full debounce SHALL follow and SHALL produce one tick.

Configuration
REQ-022 With macro DEBOUNCE_AUTOREPEAT_EN defined, a 16-bit repeat counter SHALL clear on entry to HIGH, count each cycle in HIGH, and on reaching REPEAT_CYCLES-1 emit one tick and clear; it SHALL clear on leaving HIGH and on reset.
REQ-023 Without DEBOUNCE_AUTOREPEAT_EN, no repeat counter SHALL be synthesized, REPEAT_CYCLES SHALL be ignored, and exactly one tick SHALL be produced per accepted press.

Verification
REQ-024 Reset, then btn=0 for 20 cycles -> tick=0, level=0 throughout.
REQ-025 DB_CYCLES=4: clean btn 0->1 held 50 cycles -> one tick high during the cycle after edge 7, level=1 from that cycle; macro off -> no further ticks.
REQ-026 btn bounces 1,0,1,0 (one cycle each) then holds 1 -> exactly one tick, 7 edges after the final rise; release bounce -> no tick, level returns to 0.
REQ-027 reset asserted 2 cycles before expected tick while btn held, then deasserted -> no tick at expected cycle; one tick 7 edges after reset deassertion.
REQ-028 Macro on, REPEAT_CYCLES=16, btn held 60 cycles -> ticks at press +0, +16, +32, +48 cycles after first tick; none after release.
REQ-029 tick wired to a 3-bit enable-counted downstream counter, 9 clean presses -> counter reads 1 (wrap from 7 to 0 observed once).

Source files
------------

// File: rtl/debounce_tick_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : debounce_tick_if                                                |
// | Brief    : Button / debounced-level / tick bundle for debounce_tick.       |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
interface debounce_tick_if;
  logic btn;
  logic tick;
  logic level;

  modport master (
    input  btn,
    output tick,
    output level
  );

  modport slave (
    output btn,
    input  tick,
    input  level
  );
endinterface
`default_nettype wire

// File: rtl/debounce_tick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : debounce_tick                                                   |
// | Brief    : Push-button debouncer emitting a one-cycle tick per press.      |
// |            Define DEBOUNCE_AUTOREPEAT_EN to add periodic auto-repeat ticks.|
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module debounce_tick #(
  parameter int DB_CYCLES     = 4,
  parameter int REPEAT_CYCLES = 16
) (
  input  wire logic       clk,
  input  wire logic       reset,
  debounce_tick_if.master bus
);

  typedef enum logic [1:0] {
    ST_LOW       = 2'd0,
    ST_WAIT_HIGH = 2'd1,
    ST_HIGH      = 2'd2,
    ST_WAIT_LOW  = 2'd3
  } state_t;

  localparam logic [15:0] c_db_last = 16'(DB_CYCLES - 1);

  logic        r_sync1;
  logic        r_sync2;
  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_cnt;
  logic [15:0] w_cnt_next;
  logic        r_tick;
  logic        w_tick_next;
  logic        r_level;
  logic        w_level_next;

`ifdef DEBOUNCE_AUTOREPEAT_EN
  localparam logic [15:0] c_rpt_last = 16'(REPEAT_CYCLES - 1);
  logic [15:0] r_rpt;
  logic [15:0] w_rpt_next;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= bus.btn;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_LOW;
      r_cnt   <= 16'd0;
      r_tick  <= 1'b0;
      r_level <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_tick  <= w_tick_next;
      r_level <= w_level_next;
    end
  end

`ifdef DEBOUNCE_AUTOREPEAT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rpt <= 16'd0;
    end else begin
      r_rpt <= w_rpt_next;
    end
  end
`endif

  // cnt only advances below c_db_last, so it can never wrap.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_tick_next  = 1'b0;
    case (r_state)
      ST_LOW: begin
        if (r_sync2) begin
          w_state_next = ST_WAIT_HIGH;
          w_cnt_next   = 16'd0;
        end
      end
      ST_WAIT_HIGH: begin
        if (!r_sync2) begin
          w_state_next = ST_LOW;
          w_cnt_next   = 16'd0;
        end else if (r_cnt == c_db_last) begin
          w_state_next = ST_HIGH;
          w_cnt_next   = 16'd0;
          w_tick_next  = 1'b1;
        end else begin
          w_cnt_next   = r_cnt + 16'd1;
        end
      end
      ST_HIGH: begin
        if (!r_sync2) begin
          w_state_next = ST_WAIT_LOW;
          w_cnt_next   = 16'd0;
        end
      end
      ST_WAIT_LOW: begin
        if (r_sync2) begin
          w_state_next = ST_HIGH;
          w_cnt_next   = 16'd0;
        end else if (r_cnt == c_db_last) begin
          w_state_next = ST_LOW;
          w_cnt_next   = 16'd0;
        end else begin
          w_cnt_next   = r_cnt + 16'd1;
        end
      end
      default: begin
        w_state_next = ST_LOW;
        w_cnt_next   = 16'd0;
      end
    endcase

`ifdef DEBOUNCE_AUTOREPEAT_EN
    // Repeat timer runs only while staying in HIGH; entry and exit both clear it.
    w_rpt_next = 16'd0;
    if (r_state == ST_HIGH && w_state_next == ST_HIGH) begin
      if (r_rpt == c_rpt_last) begin
        w_tick_next = 1'b1;
      end else begin
        w_rpt_next  = r_rpt + 16'd1;
      end
    end
`endif

    w_level_next = (w_state_next == ST_HIGH) || (w_state_next == ST_WAIT_LOW);
  end

  assign bus.tick  = r_tick;
  assign bus.level = r_level;

endmodule
`default_nettype wire

// File: tb/tb_debounce_tick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_debounce_tick                                                |
// | Brief    : Directed self-checking bench for debounce_tick (DB_CYCLES=4).   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_debounce_tick;

  logic clk = 1'b0;
  logic reset;

  debounce_tick_if bus ();

  debounce_tick #(
    .DB_CYCLES     (4),
    .REPEAT_CYCLES (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int         tests      = 0;
  int         fails      = 0;
  int         tick_count = 0;
  int         cyc        = 0;
  int         last_tick  = -1000;
  int         min_gap    = 1000000;
  int         wraps      = 0;
  logic [2:0] cnt3;
  int         n0;
  int         w0;

  // Monitors: tick totals, minimum spacing, and a 3-bit enable-counted counter.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.tick) begin
      tick_count <= tick_count + 1;
      if (cyc - last_tick < min_gap) min_gap <= cyc - last_tick;
      last_tick <= cyc;
    end
    if (reset) begin
      cnt3 <= 3'd0;
    end else if (bus.tick) begin
      cnt3 <= cnt3 + 3'd1;
      if (cnt3 == 3'd7) wraps <= wraps + 1;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    reset   = 1'b1;
    bus.btn = 1'b0;
    step(3);
    check("rst_tick", 32'(bus.tick), 32'd0);
    check("rst_level", 32'(bus.level), 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      step(1);
      check("idle_tick", 32'(bus.tick), 32'd0);
      check("idle_level", 32'(bus.level), 32'd0);
    end

    // Clean press: btn first sampled at edge 1, tick expected after edge 7.
    bus.btn = 1'b1;
    step(6);
    check("press_e6_tick", 32'(bus.tick), 32'd0);
    check("press_e6_level", 32'(bus.level), 32'd0);
    step(1);
    check("press_e7_tick", 32'(bus.tick), 32'd1);
    check("press_e7_level", 32'(bus.level), 32'd1);

`ifdef DEBOUNCE_AUTOREPEAT_EN
    for (int k = 1; k <= 3; k++) begin
      step(15);
      check("rpt_gap_tick", 32'(bus.tick), 32'd0);
      step(1);
      check("rpt_tick", 32'(bus.tick), 32'd1);
      check("rpt_level", 32'(bus.level), 32'd1);
    end
    step(5);
    bus.btn = 1'b0;
    n0 = tick_count;
    step(25);
    check("rpt_release_ticks", 32'(tick_count - n0), 32'd0);
    check("rpt_release_level", 32'(bus.level), 32'd0);
`else
    step(1);
    check("press_e8_tick", 32'(bus.tick), 32'd0);
    check("press_e8_level", 32'(bus.level), 32'd1);
    n0 = tick_count;
    step(48);
    check("hold_no_ticks", 32'(tick_count - n0), 32'd0);
    check("hold_level", 32'(bus.level), 32'd1);

    bus.btn = 1'b0;
    step(6);
    check("release_e6_level", 32'(bus.level), 32'd1);
    step(1);
    check("release_e7_level", 32'(bus.level), 32'd0);
    check("release_e7_tick", 32'(bus.tick), 32'd0);
    step(3);

    // Bouncing press 1,0,1,0 then hold 1.
    n0 = tick_count;
    bus.btn = 1'b1; step(1);
    bus.btn = 1'b0; step(1);
    bus.btn = 1'b1; step(1);
    bus.btn = 1'b0; step(1);
    bus.btn = 1'b1;
    step(6);
    check("bounce_e6_tick", 32'(bus.tick), 32'd0);
    check("bounce_e6_level", 32'(bus.level), 32'd0);
    check("bounce_early_ticks", 32'(tick_count - n0), 32'd0);
    step(1);
    check("bounce_e7_tick", 32'(bus.tick), 32'd1);
    check("bounce_e7_level", 32'(bus.level), 32'd1);
    step(10);
    check("bounce_one_tick", 32'(tick_count - n0), 32'd1);

    // Bouncing release 0,1,0,1 then hold 0.
    n0 = tick_count;
    bus.btn = 1'b0; step(1);
    bus.btn = 1'b1; step(1);
    bus.btn = 1'b0; step(1);
    bus.btn = 1'b1; step(1);
    bus.btn = 1'b0;
    step(6);
    check("rel_bounce_e6_level", 32'(bus.level), 32'd1);
    step(1);
    check("rel_bounce_e7_level", 32'(bus.level), 32'd0);
    check("rel_bounce_ticks", 32'(tick_count - n0), 32'd0);
    step(3);

    // Reset two cycles before the expected tick, with btn still held.
    bus.btn = 1'b1;
    step(5);
    reset = 1'b1;
    step(1);
    check("midrst_e6_level", 32'(bus.level), 32'd0);
    step(1);
    check("midrst_e7_tick", 32'(bus.tick), 32'd0);
    check("midrst_e7_level", 32'(bus.level), 32'd0);
    reset = 1'b0;
    n0 = tick_count;
    step(6);
    check("postrst_e6_tick", 32'(bus.tick), 32'd0);
    step(1);
    check("postrst_e7_tick", 32'(bus.tick), 32'd1);
    check("postrst_e7_level", 32'(bus.level), 32'd1);
    step(1);
    check("postrst_one_tick", 32'(tick_count - n0), 32'd1);
    bus.btn = 1'b0;
    step(10);
    check("postrst_release_level", 32'(bus.level), 32'd0);

    // Nine clean presses into a 3-bit counter: one wrap, ends at 1.
    reset = 1'b1;
    step(2);
    reset = 1'b0;
    w0 = wraps;
    for (int p = 0; p < 9; p++) begin
      bus.btn = 1'b1;
      step(12);
      bus.btn = 1'b0;
      step(12);
    end
    check("cnt3_value", 32'(cnt3), 32'd1);
    check("cnt3_wraps", 32'(wraps - w0), 32'd1);
    check("min_tick_gap_ok", 32'(min_gap >= 8), 32'd1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
